// File: rtl/apb_interconnect_pkg.sv
// Shared definitions for the APB interconnect: slave indices, address
// regions and a small region helper. Used by apb_addr_decode and
// apb_interconnect (optional access timeout: APB_TIMEOUT_EN).
package apb_interconnect_pkg;

  localparam int NUM_SLAVES = 5;

  // Slave index; SLV_NONE marks an unmapped address.
  typedef enum logic [2:0] {
    SLV_SRAM   = 3'd0,
    SLV_UART   = 3'd1,
    SLV_SYSTEM = 3'd2,
    SLV_INTC   = 3'd3,
    SLV_TIMER  = 3'd4,
    SLV_NONE   = 3'd5
  } slv_idx_e;

  // Region bounds (inclusive), 32-bit physical map.
  localparam logic [31:0] SRAM_BASE    = 32'h8000_0000;
  localparam logic [31:0] SRAM_LIMIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] UART_BASE    = 32'h1000_0000;
  localparam logic [31:0] UART_LIMIT   = 32'h1000_0FFF;
  localparam logic [31:0] SYSTEM_BASE  = 32'h0000_0000;
  localparam logic [31:0] SYSTEM_LIMIT = 32'h0000_FFFF;
  localparam logic [31:0] INTC_BASE    = 32'h0C00_0000;
  localparam logic [31:0] INTC_LIMIT   = 32'h0CFF_FFFF;
  localparam logic [31:0] TIMER_BASE   = 32'h0200_0000;
  localparam logic [31:0] TIMER_LIMIT  = 32'h0200_FFFF;

  // Tables indexed by slv_idx_e (SLV_SRAM..SLV_TIMER).
  localparam logic [31:0] SLV_BASE [NUM_SLAVES] = '{
    SRAM_BASE, UART_BASE, SYSTEM_BASE, INTC_BASE, TIMER_BASE
  };
  localparam logic [31:0] SLV_LIMIT [NUM_SLAVES] = '{
    SRAM_LIMIT, UART_LIMIT, SYSTEM_LIMIT, INTC_LIMIT, TIMER_LIMIT
  };

  // Order in which regions are matched; first hit wins.
  localparam slv_idx_e DECODE_PRIO [NUM_SLAVES] = '{
    SLV_SRAM, SLV_SYSTEM, SLV_TIMER, SLV_INTC, SLV_UART
  };

  // Size of a region minus one; lets the decoder use a single unsigned
  // compare (addr - base <= span) instead of two bound checks.
  function automatic logic [31:0] region_span(input slv_idx_e s);
    return SLV_LIMIT[s] - SLV_BASE[s];
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Address decoder: paddr -> one-hot slave hit vector (bit index = slv_idx_e).
// Purely combinational; all-zero output means the address is unmapped.
module apb_addr_decode
  import apb_interconnect_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  output logic [NUM_SLAVES-1:0] hit_o
);

  logic [31:0]           addr32;
  logic                  upper_zero;
  logic [NUM_SLAVES-1:0] raw_hit;
  logic [NUM_SLAVES:0]   taken;

  // The map lives in a 32-bit space; wider buses must have zero upper bits.
  generate
    if (ADDR_WIDTH > 32) begin : g_addr_wide
      assign addr32     = paddr_i[31:0];
      assign upper_zero = ~|paddr_i[ADDR_WIDTH-1:32];
    end else if (ADDR_WIDTH == 32) begin : g_addr_exact
      assign addr32     = paddr_i;
      assign upper_zero = 1'b1;
    end else begin : g_addr_narrow
      assign addr32     = {{(32-ADDR_WIDTH){1'b0}}, paddr_i};
      assign upper_zero = 1'b1;
    end
  endgenerate

  // Raw region match for every slave.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_range
      assign raw_hit[gi] = upper_zero &
        ((addr32 - SLV_BASE[gi]) <= region_span(slv_idx_e'(gi)));
    end
  endgenerate

  // Priority chain: guarantees one-hot output even if regions overlapped.
  assign taken[0] = 1'b0;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_prio
      assign hit_o[DECODE_PRIO[gi]] = raw_hit[DECODE_PRIO[gi]] & ~taken[gi];
      assign taken[gi+1]            = taken[gi] | raw_hit[DECODE_PRIO[gi]];
    end
  endgenerate

endmodule

// File: rtl/apb_interconnect.sv
// Single-master APB interconnect: decodes paddr to one of five slaves
// (sram, uart, system, intc, timer), muxes back prdata/pready/perr and
// completes unmapped accesses with an error in one access cycle.
// Optional access-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_interconnect
  import apb_interconnect_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  APB_PRESET,
  input  logic [ADDR_WIDTH-1:0] APB_paddr,
  input  logic [DATA_WIDTH-1:0] APB_pdata,
  output logic [DATA_WIDTH-1:0] APB_prdata,
  input  logic                  APB_psel,
  input  logic                  APB_penable,
  input  logic                  APB_pwrite,
  input  logic [3:0]            APB_pstb,
  output logic                  APB_pready,
  output logic                  APB_perr,
  // sram
  output logic                  sram_sel,
  output logic                  sram_enable,
  input  logic [DATA_WIDTH-1:0] sram_data,
  input  logic                  sram_ready,
  input  logic                  sram_perr,
  // uart
  output logic                  uart_sel,
  output logic                  uart_enable,
  input  logic [DATA_WIDTH-1:0] uart_data,
  input  logic                  uart_ready,
  input  logic                  uart_perr,
  // system ROM/RAM
  output logic                  system_sel,
  output logic                  system_enable,
  input  logic [DATA_WIDTH-1:0] system_data,
  input  logic                  system_ready,
  input  logic                  system_perr,
  // interrupt controller
  output logic                  intc_sel,
  output logic                  intc_enable,
  input  logic [DATA_WIDTH-1:0] intc_data,
  input  logic                  intc_ready,
  input  logic                  intc_perr,
  // timer
  output logic                  timer_sel,
  output logic                  timer_enable,
  input  logic [DATA_WIDTH-1:0] timer_data,
  input  logic                  timer_ready,
  input  logic                  timer_perr
);

  logic [NUM_SLAVES-1:0]                  hit;
  logic [NUM_SLAVES-1:0]                  sel_vec;
  logic [NUM_SLAVES-1:0]                  en_vec;
  logic [NUM_SLAVES-1:0]                  ready_vec;
  logic [NUM_SLAVES-1:0]                  perr_vec;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  data_vec;
  logic [NUM_SLAVES:0][DATA_WIDTH-1:0]    data_acc;

  logic mapped;
  logic access;
  logic slv_ready;
  logic slv_perr;
  logic timeout_hit;
  logic [DATA_WIDTH-1:0] slv_data;

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decode (
    .paddr_i (APB_paddr),
    .hit_o   (hit)
  );

  // Gather slave-side signals into vectors indexed by slv_idx_e.
  assign ready_vec[SLV_SRAM]   = sram_ready;
  assign ready_vec[SLV_UART]   = uart_ready;
  assign ready_vec[SLV_SYSTEM] = system_ready;
  assign ready_vec[SLV_INTC]   = intc_ready;
  assign ready_vec[SLV_TIMER]  = timer_ready;

  assign perr_vec[SLV_SRAM]    = sram_perr;
  assign perr_vec[SLV_UART]    = uart_perr;
  assign perr_vec[SLV_SYSTEM]  = system_perr;
  assign perr_vec[SLV_INTC]    = intc_perr;
  assign perr_vec[SLV_TIMER]   = timer_perr;

  assign data_vec[SLV_SRAM]    = sram_data;
  assign data_vec[SLV_UART]    = uart_data;
  assign data_vec[SLV_SYSTEM]  = system_data;
  assign data_vec[SLV_INTC]    = intc_data;
  assign data_vec[SLV_TIMER]   = timer_data;

  assign mapped    = |hit;
  assign access    = APB_psel & APB_penable;
  assign slv_ready = |(hit & ready_vec);
  assign slv_perr  = |(hit & perr_vec);

  // AND-OR read-data mux; the decoder guarantees at most one hit.
  assign data_acc[0] = '0;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_rdmux
      assign data_acc[gi+1] = data_acc[gi] |
                              ({DATA_WIDTH{hit[gi]}} & data_vec[gi]);
    end
  endgenerate
  assign slv_data = data_acc[NUM_SLAVES];

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  assign timeout_hit = access & mapped &
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Count access-phase wait cycles; restart on completion or bus idle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!APB_psel || APB_pready) begin
      wait_cnt_d = '0;
    end else if (access && mapped && !slv_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Wait counter register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge APB_PRESET) begin
    if (APB_PRESET) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  // Without the timeout a silent slave stalls the bus indefinitely.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Select/enable fan-out; enable is withheld on the timeout cycle.
  assign sel_vec = {NUM_SLAVES{APB_psel & ~APB_PRESET}} & hit;
  assign en_vec  = {NUM_SLAVES{access & ~APB_PRESET & ~timeout_hit}} & hit;

  assign sram_sel      = sel_vec[SLV_SRAM];
  assign uart_sel      = sel_vec[SLV_UART];
  assign system_sel    = sel_vec[SLV_SYSTEM];
  assign intc_sel      = sel_vec[SLV_INTC];
  assign timer_sel     = sel_vec[SLV_TIMER];
  assign sram_enable   = en_vec[SLV_SRAM];
  assign uart_enable   = en_vec[SLV_UART];
  assign system_enable = en_vec[SLV_SYSTEM];
  assign intc_enable   = en_vec[SLV_INTC];
  assign timer_enable  = en_vec[SLV_TIMER];

  // Master response: quiet outside the access phase and during reset;
  // unmapped or timed-out accesses complete with an error and zero data.
  always_comb begin
    APB_pready = 1'b0;
    APB_perr   = 1'b0;
    APB_prdata = '0;
    if (!APB_PRESET && access) begin
      if (!mapped || timeout_hit) begin
        APB_pready = 1'b1;
        APB_perr   = 1'b1;
      end else begin
        APB_pready = slv_ready;
        APB_perr   = slv_perr;
        APB_prdata = slv_data;
      end
    end
  end

  // Write data, direction and strobes go straight to the slaves.
  logic unused_ok;
  assign unused_ok = ^{clk, APB_pdata, APB_pwrite, APB_pstb};

endmodule

// File: tb/tb_apb_interconnect.sv
// Self-checking bench for apb_interconnect: directed scenarios followed by
// randomized transactions checked against a reference model of the address
// map and response rules. Honours APB_TIMEOUT_EN when defined.
module tb_apb_interconnect;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pdata;
  logic          psel, penable, pwrite;
  logic [3:0]    pstb;
  logic [DW-1:0] prdata;
  logic          pready, perr;
  // index order: 0 sram, 1 uart, 2 system, 3 intc, 4 timer
  logic [4:0]    sel, en;
  logic [DW-1:0] s_data [5];
  logic          s_ready [5];
  logic          s_perr [5];

  apb_interconnect #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .APB_PRESET(rst),
    .APB_paddr(paddr), .APB_pdata(pdata), .APB_prdata(prdata),
    .APB_psel(psel), .APB_penable(penable), .APB_pwrite(pwrite),
    .APB_pstb(pstb), .APB_pready(pready), .APB_perr(perr),
    .sram_sel(sel[0]), .sram_enable(en[0]), .sram_data(s_data[0]),
    .sram_ready(s_ready[0]), .sram_perr(s_perr[0]),
    .uart_sel(sel[1]), .uart_enable(en[1]), .uart_data(s_data[1]),
    .uart_ready(s_ready[1]), .uart_perr(s_perr[1]),
    .system_sel(sel[2]), .system_enable(en[2]), .system_data(s_data[2]),
    .system_ready(s_ready[2]), .system_perr(s_perr[2]),
    .intc_sel(sel[3]), .intc_enable(en[3]), .intc_data(s_data[3]),
    .intc_ready(s_ready[3]), .intc_perr(s_perr[3]),
    .timer_sel(sel[4]), .timer_enable(en[4]), .timer_data(s_data[4]),
    .timer_ready(s_ready[4]), .timer_perr(s_perr[4])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_wait  = 0;   // model: consecutive wait cycles of the current access

  logic [4:0]    exp_sel, exp_en;
  logic          exp_pready, exp_perr;
  logic [DW-1:0] exp_prdata;

  logic [31:0] bases  [5] = '{32'h8000_0000, 32'h1000_0000, 32'h0000_0000,
                              32'h0C00_0000, 32'h0200_0000};
  logic [31:0] limits [5] = '{32'hFFFF_FFFF, 32'h1000_0FFF, 32'h0000_FFFF,
                              32'h0CFF_FFFF, 32'h0200_FFFF};

  // Address map in priority order; 5 = unmapped.
  function automatic int region(input logic [31:0] a);
    if (a[31]) return 0;
    if (a <= 32'h0000_FFFF) return 2;
    if (a >= 32'h0200_0000 && a <= 32'h0200_FFFF) return 4;
    if (a >= 32'h0C00_0000 && a <= 32'h0CFF_FFFF) return 3;
    if (a >= 32'h1000_0000 && a <= 32'h1000_0FFF) return 1;
    return 5;
  endfunction

  // Reference model: expected outputs for the current inputs and wait count.
  task automatic model();
    int  r;
    bit  acc, tmo;
    r = region(paddr);
    acc = psel && penable;
    tmo = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo = acc && (r < 5) && (m_wait == TO);
`endif
    exp_sel = '0; exp_en = '0;
    exp_pready = 1'b0; exp_perr = 1'b0; exp_prdata = '0;
    if (!rst) begin
      if (psel && r < 5) exp_sel[r] = 1'b1;
      if (acc && r < 5 && !tmo) exp_en[r] = 1'b1;
      if (acc) begin
        if (r == 5 || tmo) begin
          exp_pready = 1'b1; exp_perr = 1'b1;
        end else begin
          exp_pready = s_ready[r]; exp_perr = s_perr[r]; exp_prdata = s_data[r];
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    model();
    n_tests++;
    assert (sel === exp_sel) else begin
      n_fail++; $error("FAIL %s sel: got %b want %b", tag, sel, exp_sel);
    end
    n_tests++;
    assert (en === exp_en) else begin
      n_fail++; $error("FAIL %s enable: got %b want %b", tag, en, exp_en);
    end
    n_tests++;
    assert (pready === exp_pready) else begin
      n_fail++; $error("FAIL %s pready: got %b want %b", tag, pready, exp_pready);
    end
    n_tests++;
    assert (perr === exp_perr) else begin
      n_fail++; $error("FAIL %s perr: got %b want %b", tag, perr, exp_perr);
    end
    n_tests++;
    assert (prdata === exp_prdata) else begin
      n_fail++; $error("FAIL %s prdata: got %h want %h", tag, prdata, exp_prdata);
    end
    $display("[TB] %s addr=%h psel=%b pen=%b sel=%b en=%b pready=%b perr=%b prdata=%h",
             tag, paddr, psel, penable, sel, en, pready, perr, prdata);
  endtask

  // Explicit constant check for directed scenarios.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++; $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Check mid-cycle, then advance the model's wait counter at the edge.
  task automatic tick(input string tag);
    int r;
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    r = region(paddr);
    if (rst || !psel || exp_pready) m_wait = 0;
    else if (psel && penable && r < 5 && !s_ready[r]) m_wait++;
    #1;
  endtask

  task automatic rand_slaves();
    for (int i = 0; i < 5; i++) begin
      s_data[i]  = $urandom;
      s_ready[i] = 1'($urandom_range(0, 1));
      s_perr[i]  = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic s, input logic e);
    paddr = a; psel = s; penable = e;
    pwrite = 1'($urandom_range(0, 1)); pstb = 4'($urandom); pdata = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits, r, maxw;
    logic [31:0] a;

    // Reset with an active unmapped access on the bus: everything quiet.
    rst = 1'b1;
    rand_slaves();
    drive(32'h2000_0000, 1'b1, 1'b1);
    tick("reset");
    check_val("reset_pready", {31'd0, pready}, 32'd0);
    rst = 1'b0;
    drive(32'h0, 1'b0, 1'b0);
    tick("idle");

    // SRAM read, ready immediately.
    drive(32'h8000_0010, 1'b1, 1'b0);
    tick("sram_setup");
    s_data[0] = 32'hDEAD_BEEF; s_ready[0] = 1'b1; s_perr[0] = 1'b0;
    penable = 1'b1;
    tick("sram_access");
    check_val("sram_prdata", prdata, 32'hDEAD_BEEF);
    check_val("sram_sel_only", {27'd0, sel}, 32'h1);

    // UART write with three wait states.
    drive(32'h1000_0000, 1'b1, 1'b0); pwrite = 1'b1;
    tick("uart_setup");
    penable = 1'b1; s_ready[1] = 1'b0; s_perr[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("uart_wait");
      check_val("uart_wait_pready", {31'd0, pready}, 32'd0);
    end
    s_ready[1] = 1'b1;
    tick("uart_done");
    check_val("uart_done_pready", {31'd0, pready}, 32'd1);
    check_val("uart_done_perr", {31'd0, perr}, 32'd0);

    // Unmapped access: error completion in the access cycle.
    drive(32'h2000_0000, 1'b1, 1'b0);
    tick("unmapped_setup");
    penable = 1'b1;
    tick("unmapped_access");
    check_val("unmapped_perr", {31'd0, perr}, 32'd1);
    check_val("unmapped_sel", {27'd0, sel}, 32'd0);

    // Timer error forwarded.
    drive(32'h0200_0004, 1'b1, 1'b0);
    tick("timer_setup");
    penable = 1'b1; s_ready[4] = 1'b1; s_perr[4] = 1'b1;
    tick("timer_access");
    check_val("timer_perr", {31'd0, perr}, 32'd1);

    // Asynchronous reset in the middle of an intc access.
    drive(32'h0C00_0000, 1'b1, 1'b0);
    tick("intc_setup");
    penable = 1'b1; s_ready[3] = 1'b0;
    tick("intc_wait");
    #2; rst = 1'b1; #1;
    check_all("async_reset");
    check_val("async_reset_intc_sel", {31'd0, sel[3]}, 32'd0);
    m_wait = 0;
    #1; rst = 1'b0; psel = 1'b0; penable = 1'b0;
    tick("post_reset");

`ifdef APB_TIMEOUT_EN
    // SRAM that never answers: timeout after exactly TO wait cycles.
    drive(32'h8000_0100, 1'b1, 1'b0);
    s_ready[0] = 1'b0;
    tick("tmo_setup");
    penable = 1'b1;
    waits = 0;
    for (int i = 0; i < TO + 4; i++) begin
      tick("tmo_access");
      if (pready) break;
      waits++;
    end
    check_val("tmo_wait_cycles", 32'(waits), 32'(TO));
    check_val("tmo_perr", {31'd0, perr}, 32'd1);
    psel = 1'b0; penable = 1'b0;
    tick("tmo_idle");
`endif

    // Randomized transactions over all regions, edges and unmapped space.
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 7);
      if (r < 5) begin
        a = bases[r] + ($urandom % (limits[r] - bases[r] + 32'd1));
      end else if (r == 5) begin
        a = $urandom;
      end else begin
        r = $urandom_range(0, 4);
        case ($urandom_range(0, 3))
          0: a = bases[r];
          1: a = limits[r];
          2: a = limits[r] + 32'd1;
          default: a = bases[r] - 32'd1;
        endcase
      end
      if ($urandom_range(0, 3) == 0) begin
        rand_slaves();
        drive(a, 1'b0, 1'b0);
        tick("rnd_idle");
      end
      rand_slaves();
      drive(a, 1'b1, 1'b0);
      tick("rnd_setup");
      penable = 1'b1;
      maxw = $urandom_range(0, 6);
      r = region(a);
      for (int w = 0; w <= maxw; w++) begin
        rand_slaves();
        if (w == maxw && r < 5) s_ready[r] = 1'b1;
        tick("rnd_access");
        if (exp_pready) break;
      end
      psel = 1'b0; penable = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
